// File: rtl/sp_mem_arb.sv
// Round-robin sequencer sharing one single-port byte-write RAM between two requesters.
// Grant is combinational; read data returns READ_LATENCY cycles after acceptance, never back-pressured.
module sp_mem_arb #(
    parameter  int NB_COL       = 2,
    parameter  int COL_WIDTH    = 8,
    parameter  int ADDR_W       = 10,
    parameter  int READ_LATENCY = 2,
    localparam int DW           = NB_COL * COL_WIDTH
) (
    input  logic              clka,
    input  logic              rsta,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [NB_COL-1:0] req0_we,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DW-1:0]     req0_wdata,
    output logic              rsp0_valid,
    output logic [DW-1:0]     rsp0_rdata,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [NB_COL-1:0] req1_we,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DW-1:0]     req1_wdata,
    output logic              rsp1_valid,
    output logic [DW-1:0]     rsp1_rdata,
    output logic              mem_ena,
    output logic [NB_COL-1:0] mem_wea,
    output logic [ADDR_W-1:0] mem_addra,
    output logic [DW-1:0]     mem_dina,
    output logic              mem_regcea,
    output logic              mem_rsta,
    input  logic [DW-1:0]     mem_douta
);

    logic                    r_last_grant;
    logic [READ_LATENCY-1:0] r_vld;
    logic [READ_LATENCY-1:0] r_tag;

    logic              w_gnt0;
    logic              w_gnt1;
    logic              w_grant;
    logic              w_rd;
    logic [NB_COL-1:0] w_we;

    // On contention the requester that did not win last time is served.
    always_comb begin
        w_gnt0  = req0_valid && (!req1_valid || r_last_grant);
        w_gnt1  = req1_valid && (!req0_valid || !r_last_grant);
        w_grant = w_gnt0 || w_gnt1;
        w_we    = w_gnt1 ? req1_we : req0_we;
        w_rd    = w_grant && (w_we == '0);
    end

    assign req0_ready = w_gnt0;
    assign req1_ready = w_gnt1;

    assign mem_ena   = w_grant;
    assign mem_wea   = w_grant ? w_we : '0;
    assign mem_addra = w_gnt1 ? req1_addr : req0_addr;
    assign mem_dina  = w_gnt1 ? req1_wdata : req0_wdata;
    assign mem_rsta  = 1'b0;

    always_ff @(posedge clka or posedge rsta) begin
        if (rsta) begin
            r_last_grant <= 1'b1;
            r_vld        <= '0;
            r_tag        <= '0;
        end else begin
            if (w_grant) begin
                r_last_grant <= w_gnt1;
            end
            r_vld[0] <= w_rd;
            r_tag[0] <= w_gnt1;
            for (int i = 1; i < READ_LATENCY; i++) begin
                r_vld[i] <= r_vld[i-1];
                r_tag[i] <= r_tag[i-1];
            end
        end
    end

    // The output register only needs to load when a read sits in the first stage.
    generate
        if (READ_LATENCY == 2) begin : g_oreg
            assign mem_regcea = r_vld[0];
        end else begin : g_no_oreg
            assign mem_regcea = 1'b1;
        end
    endgenerate

    assign rsp0_valid = r_vld[READ_LATENCY-1] && !r_tag[READ_LATENCY-1];
    assign rsp1_valid = r_vld[READ_LATENCY-1] &&  r_tag[READ_LATENCY-1];
    assign rsp0_rdata = mem_douta;
    assign rsp1_rdata = mem_douta;

endmodule

// File: tb/tb_sp_mem_arb.sv
// Bench for sp_mem_arb: a READ_LATENCY=2 and a READ_LATENCY=1 instance driven in lockstep,
// each with its own RAM model, checked against a queue-based reference of the arbitration rules.
module tb_sp_mem_arb;

    localparam int DW = 16;
    localparam int AW = 10;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic          t_v0, t_v1;
    logic [1:0]    t_we0, t_we1;
    logic [AW-1:0] t_a0, t_a1;
    logic [DW-1:0] t_d0, t_d1;

    logic          a_rdy0, a_rdy1, a_rsp0v, a_rsp1v, a_ena, a_regce, a_mrst;
    logic [1:0]    a_wea;
    logic [AW-1:0] a_addr;
    logic [DW-1:0] a_din, a_rsp0d, a_rsp1d, a_dout;
    logic          b_rdy0, b_rdy1, b_rsp0v, b_rsp1v, b_ena, b_regce, b_mrst;
    logic [1:0]    b_wea;
    logic [AW-1:0] b_addr;
    logic [DW-1:0] b_din, b_rsp0d, b_rsp1d, b_dout;

    sp_mem_arb #(.NB_COL(2), .COL_WIDTH(8), .ADDR_W(AW), .READ_LATENCY(2)) u_a (
        .clka(clk), .rsta(rst),
        .req0_valid(t_v0), .req0_ready(a_rdy0), .req0_we(t_we0), .req0_addr(t_a0), .req0_wdata(t_d0),
        .rsp0_valid(a_rsp0v), .rsp0_rdata(a_rsp0d),
        .req1_valid(t_v1), .req1_ready(a_rdy1), .req1_we(t_we1), .req1_addr(t_a1), .req1_wdata(t_d1),
        .rsp1_valid(a_rsp1v), .rsp1_rdata(a_rsp1d),
        .mem_ena(a_ena), .mem_wea(a_wea), .mem_addra(a_addr), .mem_dina(a_din),
        .mem_regcea(a_regce), .mem_rsta(a_mrst), .mem_douta(a_dout)
    );

    sp_mem_arb #(.NB_COL(2), .COL_WIDTH(8), .ADDR_W(AW), .READ_LATENCY(1)) u_b (
        .clka(clk), .rsta(rst),
        .req0_valid(t_v0), .req0_ready(b_rdy0), .req0_we(t_we0), .req0_addr(t_a0), .req0_wdata(t_d0),
        .rsp0_valid(b_rsp0v), .rsp0_rdata(b_rsp0d),
        .req1_valid(t_v1), .req1_ready(b_rdy1), .req1_we(t_we1), .req1_addr(t_a1), .req1_wdata(t_d1),
        .rsp1_valid(b_rsp1v), .rsp1_rdata(b_rsp1d),
        .mem_ena(b_ena), .mem_wea(b_wea), .mem_addra(b_addr), .mem_dina(b_din),
        .mem_regcea(b_regce), .mem_rsta(b_mrst), .mem_douta(b_dout)
    );

    // Read-first byte-write RAMs; A has an output register gated by regcea.
    logic [DW-1:0] ram_a [1024];
    logic [DW-1:0] ram_b [1024];
    logic [DW-1:0] shadow [1024];
    logic [DW-1:0] qreg_a, oreg_a, qreg_b;

    always @(posedge clk) begin
        if (a_regce) oreg_a = qreg_a;
        if (a_ena) begin
            qreg_a = ram_a[a_addr];
            for (int i = 0; i < 2; i++) if (a_wea[i]) ram_a[a_addr][i*8 +: 8] = a_din[i*8 +: 8];
        end
    end
    assign a_dout = oreg_a;

    always @(posedge clk) begin
        if (b_ena) begin
            qreg_b = ram_b[b_addr];
            for (int i = 0; i < 2; i++) if (b_wea[i]) ram_b[b_addr][i*8 +: 8] = b_din[i*8 +: 8];
        end
    end
    assign b_dout = qreg_b;

    // Reference: expected responses are queued with the cycle they are due in.
    typedef struct {
        int            due;
        logic          tag;
        logic [DW-1:0] dat;
    } rsp_t;
    rsp_t qa[$];
    rsp_t qb[$];
    int   cyc    = 0;
    logic m_last = 1'b1;

    always @(posedge clk or posedge rst) begin : model
        logic          win;
        logic [1:0]    we;
        logic [AW-1:0] ad;
        logic [DW-1:0] wd;
        if (rst) begin
            qa.delete();
            qb.delete();
            m_last = 1'b1;
        end else begin
            if (qa.size() > 0 && qa[0].due == cyc) void'(qa.pop_front());
            if (qb.size() > 0 && qb[0].due == cyc) void'(qb.pop_front());
            if (t_v0 || t_v1) begin
                win = (t_v0 && t_v1) ? ~m_last : t_v1;
                we  = win ? t_we1 : t_we0;
                ad  = win ? t_a1 : t_a0;
                wd  = win ? t_d1 : t_d0;
                if (we == 2'b00) begin
                    qa.push_back('{cyc + 2, win, shadow[ad]});
                    qb.push_back('{cyc + 1, win, shadow[ad]});
                end else begin
                    for (int i = 0; i < 2; i++) if (we[i]) shadow[ad][i*8 +: 8] = wd[i*8 +: 8];
                end
                m_last = win;
            end
            cyc++;
        end
    end

    // Bits: 17..14 ready a0,a1,b0,b1; 13..12 ena; 11..8 wea; 7..4 rsp valid a0,a1,b0,b1; 3..2 regce; 1..0 mem_rsta
    function automatic logic [17:0] exp_ctl();
        logic       win, any, g0, g1, ea0, ea1, eb0, eb1, rc;
        logic [1:0] we;
        any = t_v0 || t_v1;
        win = (t_v0 && t_v1) ? ~m_last : t_v1;
        g0  = any && !win;
        g1  = any && win;
        we  = any ? (win ? t_we1 : t_we0) : 2'b00;
        ea0 = qa.size() > 0 && qa[0].due == cyc && !qa[0].tag;
        ea1 = qa.size() > 0 && qa[0].due == cyc &&  qa[0].tag;
        eb0 = qb.size() > 0 && qb[0].due == cyc && !qb[0].tag;
        eb1 = qb.size() > 0 && qb[0].due == cyc &&  qb[0].tag;
        rc  = qa.size() > 0 && qa[qa.size()-1].due == cyc + 1;
        return {g0, g1, g0, g1, any, any, we, we, ea0, ea1, eb0, eb1, rc, 1'b1, 2'b00};
    endfunction

    function automatic logic [17:0] obs_ctl();
        return {a_rdy0, a_rdy1, b_rdy0, b_rdy1, a_ena, b_ena, a_wea, b_wea,
                a_rsp0v, a_rsp1v, b_rsp0v, b_rsp1v, a_regce, b_regce, a_mrst, b_mrst};
    endfunction

    function automatic logic [115:0] exp_dat();
        logic [17:0]   e;
        logic [DW-1:0] da0, da1, db0, db1, wd;
        logic [AW-1:0] ad;
        e   = exp_ctl();
        da0 = e[7] ? qa[0].dat : 16'h0;
        da1 = e[6] ? qa[0].dat : 16'h0;
        db0 = e[5] ? qb[0].dat : 16'h0;
        db1 = e[4] ? qb[0].dat : 16'h0;
        ad  = e[13] ? (e[16] ? t_a1 : t_a0) : 10'h0;
        wd  = (e[11:10] != 2'b00) ? (e[16] ? t_d1 : t_d0) : 16'h0;
        return {da0, da1, db0, db1, ad, ad, wd, wd};
    endfunction

    function automatic logic [115:0] obs_dat();
        logic [17:0]   e;
        logic [DW-1:0] da0, da1, db0, db1, wa, wb;
        logic [AW-1:0] aa, ab;
        e   = exp_ctl();
        da0 = e[7] ? a_rsp0d : 16'h0;
        da1 = e[6] ? a_rsp1d : 16'h0;
        db0 = e[5] ? b_rsp0d : 16'h0;
        db1 = e[4] ? b_rsp1d : 16'h0;
        aa  = e[13] ? a_addr : 10'h0;
        ab  = e[13] ? b_addr : 10'h0;
        wa  = (e[11:10] != 2'b00) ? a_din : 16'h0;
        wb  = (e[11:10] != 2'b00) ? b_din : 16'h0;
        return {da0, da1, db0, db1, aa, ab, wa, wb};
    endfunction

    int vecs  = 0;
    int fails = 0;

    task automatic drv(input logic v0, input logic [1:0] we0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                       input logic v1, input logic [1:0] we1, input logic [AW-1:0] a1, input logic [DW-1:0] d1);
        t_v0 = v0; t_we0 = we0; t_a0 = a0; t_d0 = d0;
        t_v1 = v1; t_we1 = we1; t_a1 = a1; t_d1 = d1;
    endtask

    task automatic idle();
        drv(1'b0, 2'b00, 10'h0, 16'h0, 1'b0, 2'b00, 10'h0, 16'h0);
    endtask

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] d);
        ram_a[a] = d; ram_b[a] = d; shadow[a] = d;
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        idle();
        next();
        next();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle();
        @(negedge clk);
        vecs++;
        if (obs_ctl() !== 18'h00004) begin
            fails++; $display("FAIL reset_ctl got=%h exp=%h", obs_ctl(), 18'h00004);
        end
        vecs++;
        if (obs_ctl() !== exp_ctl()) begin
            fails++; $display("FAIL reset_model got=%h exp=%h", obs_ctl(), exp_ctl());
        end
        next();
        rst = 1'b0;
    endtask

    task automatic test_single_read();
        preload(10'h005, 16'hBEEF);
        for (int i = 0; i < 5; i++) begin
            if (i == 0) drv(1'b1, 2'b00, 10'h005, 16'h0, 1'b0, 2'b00, 10'h0, 16'h0);
            else idle();
            @(negedge clk);
            vecs++;
            if (obs_ctl() !== exp_ctl()) begin
                fails++; $display("FAIL single_read_ctl i=%0d got=%h exp=%h", i, obs_ctl(), exp_ctl());
            end
            vecs++;
            if (obs_dat() !== exp_dat()) begin
                fails++; $display("FAIL single_read_dat i=%0d got=%h exp=%h", i, obs_dat(), exp_dat());
            end
            vecs++;
            if ({a_rdy0, a_rsp0v, b_rsp0v, a_rsp1v, b_rsp1v} !== {i == 0, i == 2, i == 1, 1'b0, 1'b0}) begin
                fails++; $display("FAIL single_read_strobe i=%0d got=%b", i, {a_rdy0, a_rsp0v, b_rsp0v, a_rsp1v, b_rsp1v});
            end
            if (i == 2) begin
                vecs++;
                if (a_rsp0d !== 16'hBEEF) begin
                    fails++; $display("FAIL single_read_lat2 got=%h exp=BEEF", a_rsp0d);
                end
            end
            if (i == 1) begin
                vecs++;
                if (b_rsp0d !== 16'hBEEF || b_regce !== 1'b1) begin
                    fails++; $display("FAIL single_read_lat1 got=%h regce=%b exp=BEEF/1", b_rsp0d, b_regce);
                end
            end
            next();
        end
    endtask

    task automatic test_byte_write();
        preload(10'h010, 16'hAAAA);
        for (int i = 0; i < 5; i++) begin
            if (i == 0) drv(1'b0, 2'b00, 10'h0, 16'h0, 1'b1, 2'b01, 10'h010, 16'h1234);
            else if (i == 1) drv(1'b0, 2'b00, 10'h0, 16'h0, 1'b1, 2'b00, 10'h010, 16'h0);
            else idle();
            @(negedge clk);
            vecs++;
            if (obs_ctl() !== exp_ctl()) begin
                fails++; $display("FAIL byte_write_ctl i=%0d got=%h exp=%h", i, obs_ctl(), exp_ctl());
            end
            vecs++;
            if (obs_dat() !== exp_dat()) begin
                fails++; $display("FAIL byte_write_dat i=%0d got=%h exp=%h", i, obs_dat(), exp_dat());
            end
            vecs++;
            if ({a_rsp1v, b_rsp1v, a_rsp0v, b_rsp0v} !== {i == 3, i == 2, 1'b0, 1'b0}) begin
                fails++; $display("FAIL byte_write_strobe i=%0d got=%b", i, {a_rsp1v, b_rsp1v, a_rsp0v, b_rsp0v});
            end
            if (i == 3) begin
                vecs++;
                if (a_rsp1d !== 16'hAA34) begin
                    fails++; $display("FAIL byte_write_data got=%h exp=AA34", a_rsp1d);
                end
            end
            next();
        end
    endtask

    task automatic test_contention();
        logic [DW-1:0] r1, r2;
        r1 = 16'($urandom);
        r2 = 16'($urandom);
        preload(10'h001, r1);
        preload(10'h002, r2);
        apply_reset();
        for (int i = 0; i < 9; i++) begin
            if (i < 6) drv(1'b1, 2'b00, 10'h001, 16'h0, 1'b1, 2'b00, 10'h002, 16'h0);
            else idle();
            @(negedge clk);
            vecs++;
            if (obs_ctl() !== exp_ctl()) begin
                fails++; $display("FAIL contention_ctl i=%0d got=%h exp=%h", i, obs_ctl(), exp_ctl());
            end
            vecs++;
            if (obs_dat() !== exp_dat()) begin
                fails++; $display("FAIL contention_dat i=%0d got=%h exp=%h", i, obs_dat(), exp_dat());
            end
            vecs++;
            if ({a_rdy0, a_rdy1, a_rsp0v, a_rsp1v} !==
                {i < 6 && i % 2 == 0, i < 6 && i % 2 == 1,
                 i >= 2 && i < 8 && i % 2 == 0, i >= 2 && i < 8 && i % 2 == 1}) begin
                fails++; $display("FAIL contention_order i=%0d got=%b", i, {a_rdy0, a_rdy1, a_rsp0v, a_rsp1v});
            end
            if (i >= 2 && i < 8) begin
                vecs++;
                if ((i % 2 == 0) ? (a_rsp0d !== r1) : (a_rsp1d !== r2)) begin
                    fails++; $display("FAIL contention_data i=%0d got=%h/%h exp=%h/%h", i, a_rsp0d, a_rsp1d, r1, r2);
                end
            end
            next();
        end
    endtask

    task automatic test_hazard();
        preload(10'h020, 16'h1111);
        for (int i = 0; i < 7; i++) begin
            if (i == 0 || i == 3) drv(1'b1, 2'b00, 10'h020, 16'h0, 1'b0, 2'b00, 10'h0, 16'h0);
            else if (i == 1) drv(1'b0, 2'b00, 10'h0, 16'h0, 1'b1, 2'b11, 10'h020, 16'h2222);
            else idle();
            @(negedge clk);
            vecs++;
            if (obs_ctl() !== exp_ctl()) begin
                fails++; $display("FAIL hazard_ctl i=%0d got=%h exp=%h", i, obs_ctl(), exp_ctl());
            end
            vecs++;
            if (obs_dat() !== exp_dat()) begin
                fails++; $display("FAIL hazard_dat i=%0d got=%h exp=%h", i, obs_dat(), exp_dat());
            end
            if (i == 2 || i == 5) begin
                vecs++;
                if (a_rsp0v !== 1'b1 || a_rsp0d !== ((i == 2) ? 16'h1111 : 16'h2222)) begin
                    fails++; $display("FAIL hazard_data i=%0d got=%b/%h", i, a_rsp0v, a_rsp0d);
                end
            end
            next();
        end
    endtask

    task automatic test_reset_midflight();
        for (int i = 0; i < 9; i++) begin
            if (i == 0) drv(1'b1, 2'b00, 10'h005, 16'h0, 1'b0, 2'b00, 10'h0, 16'h0);
            else if (i == 1) begin
                drv(1'b0, 2'b00, 10'h0, 16'h0, 1'b1, 2'b00, 10'h010, 16'h0);
                rst = 1'b1;
            end else if (i == 5) drv(1'b1, 2'b00, 10'h001, 16'h0, 1'b1, 2'b00, 10'h002, 16'h0);
            else idle();
            @(negedge clk);
            vecs++;
            if (obs_ctl() !== exp_ctl()) begin
                fails++; $display("FAIL midflight_ctl i=%0d got=%h exp=%h", i, obs_ctl(), exp_ctl());
            end
            vecs++;
            if (obs_dat() !== exp_dat()) begin
                fails++; $display("FAIL midflight_dat i=%0d got=%h exp=%h", i, obs_dat(), exp_dat());
            end
            if (i >= 1 && i <= 4) begin
                vecs++;
                if ({a_rsp0v, a_rsp1v, b_rsp0v, b_rsp1v} !== 4'b0000) begin
                    fails++; $display("FAIL midflight_strobe i=%0d got=%b exp=0000", i, {a_rsp0v, a_rsp1v, b_rsp0v, b_rsp1v});
                end
            end
            if (i == 5) begin
                vecs++;
                if ({a_rdy0, a_rdy1} !== 2'b10) begin
                    fails++; $display("FAIL midflight_first_grant got=%b exp=10", {a_rdy0, a_rdy1});
                end
            end
            next();
            rst = 1'b0;
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 99) == 0) begin
                idle();
                rst = 1'b1;
            end else begin
                t_v0  = ($urandom_range(0, 3) != 0);
                t_v1  = ($urandom_range(0, 3) != 0);
                t_we0 = ($urandom_range(0, 2) == 0) ? 2'($urandom) : 2'b00;
                t_we1 = ($urandom_range(0, 2) == 0) ? 2'($urandom) : 2'b00;
                t_a0  = 10'($urandom_range(0, 15));
                t_a1  = 10'($urandom_range(0, 15));
                t_d0  = 16'($urandom);
                t_d1  = 16'($urandom);
            end
            @(negedge clk);
            vecs++;
            if (obs_ctl() !== exp_ctl()) begin
                fails++; $display("FAIL random_ctl i=%0d got=%h exp=%h", i, obs_ctl(), exp_ctl());
            end
            vecs++;
            if (obs_dat() !== exp_dat()) begin
                fails++; $display("FAIL random_dat i=%0d got=%h exp=%h", i, obs_dat(), exp_dat());
            end
            next();
            rst = 1'b0;
        end
        for (int i = 0; i < 3; i++) begin
            idle();
            @(negedge clk);
            vecs++;
            if (obs_ctl() !== exp_ctl() || obs_dat() !== exp_dat()) begin
                fails++; $display("FAIL random_drain i=%0d got=%h exp=%h", i, obs_ctl(), exp_ctl());
            end
            next();
        end
    endtask

    initial begin
        for (int k = 0; k < 1024; k++) preload(10'(k), 16'($urandom));
        test_reset();
        test_single_read();
        test_byte_write();
        test_contention();
        test_hazard();
        test_reset_midflight();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, fails);
        $finish;
    end

endmodule

// File: doc/sp_mem_arb.md
Name: sp_mem_arb

Overview:
- Two-requester arbiter/sequencer for one single-port byte-write read-first block RAM instance (NB_COL columns, COL_WIDTH bits each).
- Requester 0 is the openMSP430 memory-bus side; requester 1 is the debug/loader side.
- Issues at most one access per cycle to the RAM and grants by round-robin.
- Tracks the RAM's fixed read latency and returns read data to the requester that issued the read, tagged in order.

Parameters:
- NB_COL, 2, byte columns per word; width of the byte-write enables.
- COL_WIDTH, 8, bits per column; data width DW = NB_COL*COL_WIDTH.
- ADDR_W, 10, RAM address width.
- READ_LATENCY, 2, RAM read latency in cycles. 2 means output register used; 1 means no output register. Legal values are 1 and 2 only.

Ports:
- clka  in  1  clock; all logic on rising edge.
- rsta  in  1  asynchronous active-high reset.
- req0_valid  in  1  requester 0 access request.
- req0_ready  out  1  requester 0 grant; access accepted when valid&&ready.
- req0_we  in  NB_COL  byte write enables; all-zero means read.
- req0_addr  in  ADDR_W  word address.
- req0_wdata  in  DW  write data.
- rsp0_valid  out  1  read data valid strobe for requester 0.
- rsp0_rdata  out  DW  read data; meaningful only while rsp0_valid=1.
- req1_valid, req1_ready, req1_we, req1_addr, req1_wdata, rsp1_valid, rsp1_rdata: same as the requester 0 ports, for requester 1.
- mem_ena  out  1  RAM enable.
- mem_wea  out  NB_COL  RAM byte-write enable.
- mem_addra  out  ADDR_W  RAM address.
- mem_dina  out  DW  RAM write data.
- mem_regcea  out  1  RAM output-register enable.
- mem_rsta  out  1  RAM output-register reset; tied 0.
- mem_douta  in  DW  RAM read data.

Behaviour:
- Reset values (asynchronous on rsta):
  - last_grant=1, so requester 0 wins the first contention.
  - Read-tracking pipeline cleared.
  - rsp0_valid=rsp1_valid=0.
  - Both ready outputs are combinational from valid inputs, so they are 0 when nothing is requested.
- Arbitration (combinational, same cycle):
  - Only req0_valid=1: req0_ready=1.
  - Only req1_valid=1: req1_ready=1.
  - Both valid: grant the requester not equal to last_grant.
  - At most one ready is high per cycle.
  - last_grant updates on the clock edge to the granted index only when a grant occurs; otherwise it holds.
  - ready must not depend on ready; valid may depend on nothing from this block.
- Issue (combinational):
  - mem_ena = grant occurs.
  - mem_addra/mem_wea/mem_dina = granted requester's addr/we/wdata, gated by grant.
  - mem_wea=0 when no grant; mem_addra/mem_dina are don't-care but driven from requester 0.
- Read tracking:
  - Pipeline of READ_LATENCY stages, each holding {valid, tag}.
  - Stage 0 is loaded with valid = grant && (granted we==0), tag = granted index.
  - Stages shift every cycle unconditionally; no backpressure on responses.
  - mem_regcea = stage 0 valid when READ_LATENCY=2; tied 1 when READ_LATENCY=1.
- Response:
  - Read accepted at edge T gives rspN_valid=1 for exactly one cycle, in the cycle after edge T+READ_LATENCY-1, i.e. READ_LATENCY cycles after acceptance.
  - rspN_rdata = mem_douta, combinational pass-through.
  - Reads return in issue order; back-to-back reads give back-to-back responses.
- Writes:
  - Any nonzero we is a write: one cycle, no response.
  - Read-first old data from a write is never presented.
  - A write to an address with an outstanding read does not alter that read's returned data. The read was sampled at its issue edge.
- Boundaries:
  - Continuous contention alternates 0,1,0,1...; neither requester waits more than 1 cycle.
  - A requester dropping valid while not granted is legal; no state change results.
  - rsta asserted mid-operation: in-flight reads are discarded and no rsp strobes appear after rsta deasserts. RAM contents are not affected by this block's reset.
  - Address wrap is not applicable; the address is passed through unmodified.

Test Plan:
- Single read: reset, RAM preloaded addr 0x005=0xBEEF, READ_LATENCY=2. req0 read 0x005 at cycle 0 -> req0_ready=1 in cycle 0, rsp0_valid=1 with rdata 0xBEEF in cycle 2 only; rsp1_valid stays 0.
- Byte write then read: req1 write addr 0x010, we=2'b01, wdata 0x1234 over prior 0xAAAA, then read 0x010 -> rsp1_rdata=0xAA34; write produces no rsp strobe.
- Contention: both requesters hold valid reads to 0x001/0x002 for 6 cycles -> grants 0,1,0,1,0,1; responses alternate rsp0/rsp1 from cycle 2 with the correct data each.
- Write/read hazard: req0 read 0x020 (=0x1111) in cycle 0, req1 write 0x020=0x2222 in cycle 1 -> rsp0_rdata=0x1111 in cycle 2; a later read of 0x020 returns 0x2222.
- Reset mid-flight: two reads issued in cycles 0 and 1, rsta pulsed in cycle 1 -> no rsp0/rsp1 strobe in cycles 2-4; after reset, first contention grants requester 0.
- READ_LATENCY=1 build: req0 read 0x005 (=0xBEEF) -> rsp0_valid with 0xBEEF one cycle after acceptance; mem_regcea constant 1.
